// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM-like bus arbiter: requester tags, grant FSM states
// and the transfer-size encoding used on the request fields.
package sram_arb_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_INST = 2'd1,
    HOLD_DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO: one entry per accepted-but-unanswered transaction, holding
// which requester issued it. The head tag routes the next slave response.
module arb_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUT = 2,
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
  localparam int CW = $clog2(MAX_OUT) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  src_e          push_tag,
  input  logic          pop,
  output src_e          head_tag,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  src_e          tags [MAX_OUT];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(MAX_OUT));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_tag = tags[rd_ptr];

  // Pointers wrap modulo MAX_OUT; count tracks occupancy, unchanged on push+pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) tags[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like master port between the inst-fetch and data ports.
// Handshake rule (both sides): a request transfers on a cycle where req=1 and
// addr_ok=1; once req is raised the requester holds req and all fields stable
// until addr_ok. Responses (data_ok) return strictly in acceptance order and are
// routed back using the tag FIFO. dbg_* outputs expose FSM and counter state.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUT      = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW = $clog2(MAX_OUT) + 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic          inst_wr,
  input  logic [1:0]    inst_size,
  input  logic [3:0]    inst_wstrb,
  input  logic [31:0]   inst_addr,
  input  logic [31:0]   inst_wdata,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [3:0]    data_wstrb,
  input  logic [31:0]   data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [31:0]   data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [31:0]   mem_rdata,
  output logic          err_unexp,
  output arb_state_e    dbg_state,
  output logic [CW-1:0] dbg_count,
  output logic [SW-1:0] dbg_starve_cnt
);

  arb_state_e    state, state_nxt;
  logic          grant_vld;
  src_e          grant_src;
  logic          handshake;
  logic [SW-1:0] starve_cnt;
  src_e          head_tag;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  arb_tag_fifo #(.MAX_OUT(MAX_OUT)) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (handshake),
    .push_tag (grant_src),
    .pop      (mem_data_ok),
    .head_tag (head_tag),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Grant state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Grant selection: fresh arbitration in IDLE, locked source while holding.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_INST;
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (!full) begin
          if (starve_cnt == SW'(STARVE_LIMIT) && inst_req) begin
            grant_vld = 1'b1;
            grant_src = SRC_INST;
          end else if (data_req) begin
            grant_vld = 1'b1;
            grant_src = SRC_DATA;
          end else if (inst_req) begin
            grant_vld = 1'b1;
            grant_src = SRC_INST;
          end
        end
      end
      HOLD_INST: begin
        grant_vld = 1'b1;
        grant_src = SRC_INST;
      end
      HOLD_DATA: begin
        grant_vld = 1'b1;
        grant_src = SRC_DATA;
      end
      default: ;
    endcase
    if (grant_vld && !mem_addr_ok)
      state_nxt = (grant_src == SRC_DATA) ? HOLD_DATA : HOLD_INST;
  end

  assign mem_req   = grant_vld;
  assign mem_wr    = (grant_src == SRC_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (grant_src == SRC_DATA) ? data_size  : inst_size;
  assign mem_wstrb = (grant_src == SRC_DATA) ? data_wstrb : inst_wstrb;
  assign mem_addr  = (grant_src == SRC_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (grant_src == SRC_DATA) ? data_wdata : inst_wdata;

  assign handshake    = mem_req & mem_addr_ok;
  assign inst_addr_ok = handshake & (grant_src == SRC_INST);
  assign data_addr_ok = handshake & (grant_src == SRC_DATA);

  assign inst_data_ok = mem_data_ok & ~empty & (head_tag == SRC_INST);
  assign data_data_ok = mem_data_ok & ~empty & (head_tag == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Starvation counter: data wins while inst waits, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!resetn)
      starve_cnt <= '0;
    else if (!inst_req || inst_addr_ok)
      starve_cnt <= '0;
    else if (data_addr_ok && starve_cnt != SW'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end

  // Sticky flag for a slave response with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!resetn)                  err_unexp <= 1'b0;
    else if (mem_data_ok && empty) err_unexp <= 1'b1;
  end

  assign dbg_state      = state;
  assign dbg_count      = count;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: grant priority, hold behaviour, full
// blocking, starvation forcing, unexpected response flag and mid-stream reset.
module tb_sram_bus_arbiter;
  import sram_arb_pkg::*;

  localparam int MAX_OUT      = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [31:0] INST_ADDR = 32'h1c00_0000;
  localparam logic [31:0] DATA_ADDR = 32'h8000_1000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          inst_req, inst_wr, data_req, data_wr;
  logic [1:0]    inst_size, data_size;
  logic [3:0]    inst_wstrb, data_wstrb;
  logic [31:0]   inst_addr, inst_wdata, data_addr, data_wdata;
  logic          inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0]   inst_rdata, data_rdata;
  logic          mem_req, mem_wr;
  logic [1:0]    mem_size;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_addr_ok, mem_data_ok;
  logic [31:0]   mem_rdata;
  logic          err_unexp;
  arb_state_e    dbg_state;
  logic [CW-1:0] dbg_count;
  logic [SW-1:0] dbg_starve_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Expected response routing, in order: 0 = inst, 1 = data.
  logic [0:0] exp_q[$];

  sram_bus_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err_unexp(err_unexp), .dbg_state(dbg_state), .dbg_count(dbg_count),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD; inst_wstrb = 4'h0;
    inst_addr = INST_ADDR; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD; data_wstrb = 4'h0;
    data_addr = DATA_ADDR; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
  endtask

  // Called in a cycle where mem_data_ok is driven high: the pulse must land on
  // the requester at the head of the expected queue.
  task automatic check_resp(input string tag);
    logic [0:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_inst_ok"}, inst_data_ok, (e == 1'b0));
      check({tag, "_data_ok"}, data_data_ok, (e == 1'b1));
      check({tag, "_rdata"}, (e == 1'b0) ? inst_rdata : data_rdata, mem_rdata);
    end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;

    // Reset state
    settle();
    check("rst_mem_req", mem_req, 0);
    check("rst_err", err_unexp, 0);
    check("rst_count", dbg_count, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_starve", dbg_starve_cnt, 0);

    // 1: inst only, accepted at once, answered next cycle
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    settle();
    check("t1_mem_req", mem_req, 1);
    check("t1_mem_addr", mem_addr, INST_ADDR);
    check("t1_inst_addr_ok", inst_addr_ok, 1);
    check("t1_data_addr_ok", data_addr_ok, 0);
    exp_q.push_back(1'b0);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hdead_beef;
    settle();
    check("t1_count", dbg_count, 1);
    check_resp("t1_resp");
    tick();
    mem_data_ok = 1'b0;
    settle();
    check("t1_count_after", dbg_count, 0);
    check("t1_no_inst_ok", inst_data_ok, 0);

    // 2: simultaneous requests, data first then inst
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hf;
    data_wdata = 32'h1234_5678; mem_addr_ok = 1'b1;
    settle();
    check("t2_mem_addr_data", mem_addr, DATA_ADDR);
    check("t2_data_addr_ok", data_addr_ok, 1);
    check("t2_inst_addr_ok0", inst_addr_ok, 0);
    check("t2_mem_wr", mem_wr, 1);
    check("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    exp_q.push_back(1'b1);
    tick();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    settle();
    check("t2_starve", dbg_starve_cnt, 1);
    check("t2_mem_addr_inst", mem_addr, INST_ADDR);
    check("t2_inst_addr_ok", inst_addr_ok, 1);
    check("t2_mem_wr0", mem_wr, 0);
    exp_q.push_back(1'b0);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0011;
    settle();
    check("t2_count", dbg_count, 2);
    check_resp("t2_resp0");
    tick();
    mem_rdata = 32'h0000_0022;
    settle();
    check_resp("t2_resp1");
    tick();
    mem_data_ok = 1'b0;
    settle();
    check("t2_count_after", dbg_count, 0);

    // 3: data granted but stalled; inst arrives and must wait
    data_req = 1'b1; mem_addr_ok = 1'b0;
    settle();
    check("t3_mem_req", mem_req, 1);
    check("t3_mem_addr", mem_addr, DATA_ADDR);
    tick();
    inst_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t3_state_hold", dbg_state, HOLD_DATA);
      check("t3_mem_addr_hold", mem_addr, DATA_ADDR);
      check("t3_inst_addr_ok0", inst_addr_ok, 0);
      tick();
    end
    mem_addr_ok = 1'b1;
    settle();
    check("t3_data_addr_ok", data_addr_ok, 1);
    check("t3_inst_addr_ok1", inst_addr_ok, 0);
    exp_q.push_back(1'b1);
    tick();
    data_req = 1'b0;
    settle();
    check("t3_state_idle", dbg_state, IDLE);
    check("t3_inst_granted", inst_addr_ok, 1);
    exp_q.push_back(1'b0);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_0033;
    settle();
    check_resp("t3_resp0");
    tick();
    settle();
    check_resp("t3_resp1");
    tick();
    mem_data_ok = 1'b0;

    // 4: fill to MAX_OUT, third request blocked until a response frees a slot
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    settle();
    check("t4_hs1", inst_addr_ok, 1);
    exp_q.push_back(1'b0);
    tick();
    data_req = 1'b1;
    settle();
    check("t4_hs2", data_addr_ok, 1);
    exp_q.push_back(1'b1);
    tick();
    data_req = 1'b0;
    settle();
    check("t4_full_count", dbg_count, 2);
    check("t4_full_mem_req", mem_req, 0);
    check("t4_full_inst_ok", inst_addr_ok, 0);
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0044;
    settle();
    check("t4_full_same_cycle", mem_req, 0);
    check_resp("t4_resp0");
    tick();
    mem_data_ok = 1'b0;
    settle();
    check("t4_count1", dbg_count, 1);
    check("t4_resume", inst_addr_ok, 1);
    exp_q.push_back(1'b0);
    tick();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    settle();
    check("t4_starve_clr", dbg_starve_cnt, 0);
    mem_data_ok = 1'b1;
    settle();
    check_resp("t4_resp1");
    tick();
    settle();
    check_resp("t4_resp2");
    tick();
    mem_data_ok = 1'b0;
    settle();
    check("t4_count_after", dbg_count, 0);

    // 5: data floods while inst waits; inst forced after STARVE_LIMIT data wins
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    for (int k = 0; k < STARVE_LIMIT; k++) begin
      mem_data_ok = (k > 0); mem_rdata = 32'h100 + 32'(k);
      settle();
      if (k > 0) check_resp("t5_resp");
      check("t5_starve", dbg_starve_cnt, k);
      check("t5_data_addr_ok", data_addr_ok, 1);
      check("t5_inst_addr_ok0", inst_addr_ok, 0);
      exp_q.push_back(1'b1);
      tick();
    end
    settle();
    check_resp("t5_resp");
    check("t5_starve_sat", dbg_starve_cnt, STARVE_LIMIT);
    check("t5_forced_inst", inst_addr_ok, 1);
    check("t5_forced_mem_addr", mem_addr, INST_ADDR);
    check("t5_forced_no_data", data_addr_ok, 0);
    exp_q.push_back(1'b0);
    tick();
    settle();
    check_resp("t5_resp_inst");
    check("t5_starve_zero", dbg_starve_cnt, 0);
    check("t5_data_again", data_addr_ok, 1);
    exp_q.push_back(1'b1);
    tick();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    settle();
    check_resp("t5_resp_last");
    tick();
    mem_data_ok = 1'b0;
    settle();
    check("t5_count_after", dbg_count, 0);
    check("t5_err_clean", err_unexp, 0);

    // 6: unexpected response, sticky error, then mid-stream reset
    mem_data_ok = 1'b1;
    settle();
    check("t6_no_inst_ok", inst_data_ok, 0);
    check("t6_no_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t6_err_sticky", err_unexp, 1);
      check("t6_count_zero", dbg_count, 0);
      tick();
    end
    data_req = 1'b1; mem_addr_ok = 1'b1;
    settle();
    check("t6_hs", data_addr_ok, 1);
    tick();
    mem_addr_ok = 1'b0;
    settle();
    check("t6_count1", dbg_count, 1);
    check("t6_pending_req", mem_req, 1);
    resetn = 1'b0; data_req = 1'b0;
    tick();
    settle();
    check("t6_rst_count", dbg_count, 0);
    check("t6_rst_mem_req", mem_req, 0);
    check("t6_rst_err", err_unexp, 0);
    check("t6_rst_state", dbg_state, IDLE);
    resetn = 1'b1;
    mem_data_ok = 1'b0;
    exp_q.delete();
    tick();
    settle();
    check("t6_post_rst_mem_req", mem_req, 0);

    check("end_exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
